// File: rtl/arb_pkg.sv
// Shared definitions for the arbiter requester agent: state encoding and default sizing.
package arb_pkg;

    localparam int unsigned ARB_LEN_W       = 4;
    localparam int unsigned ARB_TIMEOUT_CYC = 64;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        REQ     = 3'b001,
        XFER    = 3'b010,
        RELEASE = 3'b011
    } arb_state_t;

endpackage

// File: rtl/arb_wait_timer.sv
// Grant-wait timer: counts enabled cycles since clear and flags when LIMIT-1 is reached.
module arb_wait_timer
    import arb_pkg::*;
#(
    parameter int unsigned TMR_W = 8,
    parameter int unsigned LIMIT = ARB_TIMEOUT_CYC
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [TMR_W-1:0] cnt_q, cnt_d;

    assign expire = (cnt_q == TMR_W'(LIMIT - 1));

    // Saturate at the expiry value so a stalled enable cannot wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expire) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/arb_req_agent.sv
// Requester-side agent for one port of the 4-way req/gnt arbiter.
// Define ARB_REQ_TIMEOUT_EN to abandon a request after TIMEOUT_CYC cycles without grant.
module arb_req_agent
    import arb_pkg::*;
#(
    parameter int unsigned LEN_W       = ARB_LEN_W,
    parameter int unsigned TIMEOUT_CYC = ARB_TIMEOUT_CYC,
    parameter int unsigned TMR_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             cmd_ready,
    output logic             req,
    input  logic             gnt,
    output logic             beat_valid,
    output logic [LEN_W-1:0] beat_idx,
    output logic             done,
    output logic             abort,
    output logic             timeout_err
);

    arb_state_t       state_q, state_d;
    logic             req_q, req_d;
    logic             beat_valid_q, beat_valid_d;
    logic [LEN_W-1:0] beat_idx_q, beat_idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             done_q, done_d;
    logic             abort_q, abort_d;
    logic             terr_q, terr_d;
    logic             accept;
    logic             tmr_expire;

    assign cmd_ready = !reset && (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;

`ifdef ARB_REQ_TIMEOUT_EN
    arb_wait_timer #(
        .TMR_W (TMR_W),
        .LIMIT (TIMEOUT_CYC)
    ) u_wait_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (accept),
        .enable ((state_q == REQ) && !gnt),
        .expire (tmr_expire)
    );
`else
    logic unused_tmr_cfg;
    assign unused_tmr_cfg = (TMR_W == TIMEOUT_CYC);
    assign tmr_expire     = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        beat_valid_d = beat_valid_q;
        beat_idx_d   = beat_idx_q;
        len_d        = len_q;
        done_d       = 1'b0;
        abort_d      = 1'b0;
        terr_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    len_d   = cmd_len;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                // A grant seen in the expiry cycle still wins over the timeout.
                if (gnt) begin
                    beat_valid_d = 1'b1;
                    beat_idx_d   = '0;
                    state_d      = XFER;
                end else if (tmr_expire) begin
                    req_d   = 1'b0;
                    terr_d  = 1'b1;
                    state_d = RELEASE;
                end
            end
            XFER: begin
                // Last-beat completion takes priority over a grant lost in the same cycle.
                if (beat_idx_q == len_q) begin
                    req_d        = 1'b0;
                    beat_valid_d = 1'b0;
                    done_d       = 1'b1;
                    state_d      = RELEASE;
                end else if (!gnt) begin
                    req_d        = 1'b0;
                    beat_valid_d = 1'b0;
                    abort_d      = 1'b1;
                    state_d      = RELEASE;
                end else begin
                    beat_idx_d = beat_idx_q + 1'b1;
                end
            end
            RELEASE: begin
                req_d = 1'b0;
                if (!gnt) begin
                    state_d = IDLE;
                end
            end
            default: begin
                req_d        = 1'b0;
                beat_valid_d = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            req_q        <= 1'b0;
            beat_valid_q <= 1'b0;
            beat_idx_q   <= '0;
            len_q        <= '0;
            done_q       <= 1'b0;
            abort_q      <= 1'b0;
            terr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            beat_valid_q <= beat_valid_d;
            beat_idx_q   <= beat_idx_d;
            len_q        <= len_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
            terr_q       <= terr_d;
        end
    end

    assign req         = req_q;
    assign beat_valid  = beat_valid_q;
    assign beat_idx    = beat_idx_q;
    assign done        = done_q;
    assign abort       = abort_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_arb_req_agent.sv
// Randomized bench for arb_req_agent: acts as the arbiter and checks each burst transaction.
module tb_arb_req_agent;

    localparam int LEN_W = 4;
    localparam int TOC   = 8;
    localparam int NODROP = 255;

    logic             clock = 1'b0;
    logic             reset;
    logic             cmd_valid;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_ready;
    logic             req;
    logic             gnt;
    logic             beat_valid;
    logic [LEN_W-1:0] beat_idx;
    logic             done;
    logic             abort;
    logic             timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    arb_req_agent #(
        .LEN_W       (LEN_W),
        .TIMEOUT_CYC (TOC),
        .TMR_W       (8)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_len     (cmd_len),
        .cmd_ready   (cmd_ready),
        .req         (req),
        .gnt         (gnt),
        .beat_valid  (beat_valid),
        .beat_idx    (beat_idx),
        .done        (done),
        .abort       (abort),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One command: len beats-1, grant after dly req-high cycles, drop grant while beat
    // 'drop' is on the bus, keep grant 'hold' extra cycles after completion, and
    // optionally keep cmd_valid high (with junk cmd_len) the whole time.
    task automatic run_burst(input int len, input int dly, input int drop,
                             input int hold, input bit keep);
        int beats[$];
        int n_done = 0, n_abort = 0, n_terr = 0, req_hi = 0, rel = 0, req_rel = 0;
        int cyc = 0, wait_cnt = 0, hold_cnt = 0, first_c = -1, last_c = -1;
        int seq_bad = 0, both = 0, exp_nb, exp_rel;
        bit ended = 0, exp_to = 0, fin = 0;

`ifdef ARB_REQ_TIMEOUT_EN
        exp_to = (dly >= TOC);
`endif
        while (!cmd_ready && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        chk("cmd_ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        @(negedge clock);
        if (!keep) cmd_valid = 1'b0;
        cyc = 0;
        while (cyc < 300) begin
            if (req && !ended) req_hi++;
            if (beat_valid) begin
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                if (int'(beat_idx) != beats.size()) seq_bad++;
                beats.push_back(int'(beat_idx));
            end
            if (done) n_done++;
            if (abort) n_abort++;
            if (timeout_err) n_terr++;
            if (done && abort) both++;
            if (done || abort || timeout_err) ended = 1;
            if (ended) begin
                if (cmd_ready) begin
                    fin = 1;
                    break;
                end
                rel++;
                if (req) req_rel++;
            end
            if (req && !gnt && !ended) begin
                if (wait_cnt == dly) gnt = 1'b1;
                else wait_cnt++;
            end
            if (beat_valid && int'(beat_idx) == drop) gnt = 1'b0;
            if (ended && gnt) begin
                if (hold_cnt == hold) gnt = 1'b0;
                else hold_cnt++;
            end
            if (keep) cmd_len = LEN_W'($urandom);
            @(negedge clock);
            cyc++;
        end
        chk("burst_finished_in_bound", int'(fin), 1);

        exp_nb  = exp_to ? 0 : ((drop < len) ? drop + 1 : len + 1);
        exp_rel = (!exp_to && drop > len) ? hold + 1 : 1;
        chk("beat_count", beats.size(), exp_nb);
        chk("beat_seq_errors", seq_bad, 0);
        if (exp_nb > 0) begin
            chk("beat_span_no_gap", last_c - first_c + 1, exp_nb);
            chk("beat_idx_held", int'(beat_idx), exp_nb - 1);
        end
        chk("done_pulses", n_done, (!exp_to && drop >= len) ? 1 : 0);
        chk("abort_pulses", n_abort, (!exp_to && drop < len) ? 1 : 0);
        chk("timeout_pulses", n_terr, exp_to ? 1 : 0);
        chk("done_abort_together", both, 0);
        chk("req_high_cycles", req_hi, exp_to ? TOC : dly + 1 + exp_nb);
        chk("release_cycles", rel, exp_rel);
        chk("req_in_release", req_rel, 0);
    endtask

    initial begin
        int rl, rd, rdrop, rh;
        bit rk;
        bit reached;

        reset = 1'b1; cmd_valid = 1'b1; cmd_len = 4'd5; gnt = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_req", int'(req), 0);
        chk("rst_beat_valid", int'(beat_valid), 0);
        cmd_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", int'(cmd_ready), 1);
        chk("post_rst_req", int'(req), 0);
        chk("post_rst_beat_idx", int'(beat_idx), 0);
        chk("post_rst_pulses", int'({done, abort, timeout_err}), 0);

        run_burst(3, 2, NODROP, 0, 0);
        run_burst(0, 0, NODROP, 0, 0);
        run_burst(15, 1, NODROP, 0, 0);
        run_burst(7, 0, 2, 0, 0);
        run_burst(3, 1, 3, 0, 0);
        run_burst(2, 0, NODROP, 2, 1);
        run_burst(1, 1, NODROP, 2, 1);
        cmd_valid = 1'b0;
`ifdef ARB_REQ_TIMEOUT_EN
        run_burst(3, 20, NODROP, 0, 0);
        run_burst(2, TOC - 1, NODROP, 0, 0);
        run_burst(2, TOC, NODROP, 0, 0);
`else
        run_burst(1, 20, NODROP, 0, 0);
`endif

        // Reset during beat 1 of a 4-beat burst.
        reached = 0;
        cmd_valid = 1'b1; cmd_len = 4'd3;
        @(negedge clock);
        cmd_valid = 1'b0;
        gnt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (beat_valid && beat_idx == 4'd1) begin
                reached = 1;
                break;
            end
        end
        chk("mid_reset_reached_beat1", int'(reached), 1);
        reset = 1'b1; gnt = 1'b0;
        @(negedge clock);
        chk("mid_reset_req", int'(req), 0);
        chk("mid_reset_beat_valid", int'(beat_valid), 0);
        chk("mid_reset_pulses", int'({done, abort, timeout_err}), 0);
        chk("mid_reset_ready_low", int'(cmd_ready), 0);
        reset = 1'b0;
        @(negedge clock);
        chk("after_reset_ready", int'(cmd_ready), 1);
        chk("after_reset_req", int'(req), 0);
        chk("after_reset_pulses", int'({done, abort}), 0);

        for (int t = 0; t < 40; t++) begin
            rl    = int'($urandom_range(0, 15));
            rd    = int'($urandom_range(0, 10));
            rdrop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : NODROP;
            rh    = int'($urandom_range(0, 3));
            rk    = 1'($urandom_range(0, 1));
            run_burst(rl, rd, rdrop, rh, rk);
        end
        cmd_valid = 1'b0;
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
